// File: rtl/sram_bank_ctrl_if.sv
// rtl/sram_bank_ctrl_if.sv - request/response handshake bundle for the SRAM bank controller
interface sram_bank_ctrl_if #(
  parameter int AW = 3,
  parameter int W  = 15
);
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_waddr;
  logic [W-1:0]  req_wdata;
  logic [AW-1:0] req_raddr1;
  logic [AW-1:0] req_raddr2;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [W-1:0]  rsp_rd1;
  logic [W-1:0]  rsp_rd2;
  logic          rsp_err;

  modport master (
    output req_valid, req_we, req_waddr, req_wdata, req_raddr1, req_raddr2, rsp_ready,
    input  req_ready, rsp_valid, rsp_rd1, rsp_rd2, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_waddr, req_wdata, req_raddr1, req_raddr2, rsp_ready,
    output req_ready, rsp_valid, rsp_rd1, rsp_rd2, rsp_err
  );
endinterface

// File: rtl/sram_bank_ctrl.sv
// rtl/sram_bank_ctrl.sv - one-at-a-time read/write initiator for a bank of sram_1x15 cells
module sram_bank_ctrl #(
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int W     = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  sram_bank_ctrl_if.slave  bus,
  output logic [DEPTH-1:0] ws,
  output logic [DEPTH-1:0] rs1,
  output logic [DEPTH-1:0] rs2,
  output logic [W-1:0]     wd,
  input  logic [W-1:0]     rd1_bus,
  input  logic [W-1:0]     rd2_bus,
  output logic             busy
);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_RESP} state_t;

  state_t           state_q, state_d;
  logic [DEPTH-1:0] ws_q, ws_d, rs1_q, rs1_d, rs2_q, rs2_d;
  logic [W-1:0]     wd_q, wd_d;
  logic [AW-1:0]    raddr1_q, raddr1_d, raddr2_q, raddr2_d;
  logic [W-1:0]     rsp_rd1_q, rsp_rd1_d, rsp_rd2_q, rsp_rd2_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_err_q, rsp_err_d;

  // Addresses at or beyond DEPTH decode to an all-zero select.
  function automatic logic [DEPTH-1:0] onehot(input logic [AW-1:0] a);
    onehot = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (a == AW'(i)) onehot[i] = 1'b1;
    end
  endfunction

  function automatic logic in_range(input logic [AW-1:0] a);
    in_range = (32'(a) < DEPTH);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ws_q        <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      wd_q        <= '0;
      raddr1_q    <= '0;
      raddr2_q    <= '0;
      rsp_rd1_q   <= '0;
      rsp_rd2_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ws_q        <= ws_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      wd_q        <= wd_d;
      raddr1_q    <= raddr1_d;
      raddr2_q    <= raddr2_d;
      rsp_rd1_q   <= rsp_rd1_d;
      rsp_rd2_q   <= rsp_rd2_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Selects are decoded on the accepting edge so they are registered for the WRITE/READ cycle.
  always_comb begin
    state_d     = state_q;
    ws_d        = '0;
    rs1_d       = '0;
    rs2_d       = '0;
    wd_d        = wd_q;
    raddr1_d    = raddr1_q;
    raddr2_d    = raddr2_q;
    rsp_rd1_d   = rsp_rd1_q;
    rsp_rd2_d   = rsp_rd2_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          raddr1_d = bus.req_raddr1;
          raddr2_d = bus.req_raddr2;
          if (bus.req_we) begin
            ws_d    = onehot(bus.req_waddr);
            wd_d    = bus.req_wdata;
            state_d = S_WRITE;
          end else begin
            rs1_d   = onehot(bus.req_raddr1);
            rs2_d   = onehot(bus.req_raddr2);
            state_d = S_READ;
          end
        end
      end
      S_WRITE: state_d = S_IDLE;
      S_READ: begin
        rsp_rd1_d   = in_range(raddr1_q) ? rd1_bus : '0;
        rsp_rd2_d   = in_range(raddr2_q) ? rd2_bus : '0;
        rsp_err_d   = !in_range(raddr1_q) || !in_range(raddr2_q);
        rsp_valid_d = 1'b1;
        state_d     = S_RESP;
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign ws            = ws_q;
  assign rs1           = rs1_q;
  assign rs2           = rs2_q;
  assign wd            = wd_q;
  assign busy          = (state_q != S_IDLE);
  assign bus.req_ready = (state_q == S_IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rd1   = rsp_rd1_q;
  assign bus.rsp_rd2   = rsp_rd2_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_sram_bank_ctrl.sv
// tb/tb_sram_bank_ctrl.sv - scoreboard bench for sram_bank_ctrl with a six-cell bank model
module tb_sram_bank_ctrl;
  localparam int DEPTH = 6;
  localparam int AW    = 3;
  localparam int W     = 15;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [DEPTH-1:0] ws, rs1, rs2;
  logic [W-1:0]     wd, rd1_bus, rd2_bus;
  logic             busy;
  logic [W-1:0]     mem [DEPTH];

  int checks = 0;
  int failures = 0;
  logic [2*W:0] exp_q [$];
  logic [2*W:0] last_rsp;
  logic         seen = 1'b0;

  sram_bank_ctrl_if #(.AW(AW), .W(W)) bus ();

  sram_bank_ctrl #(.DEPTH(DEPTH), .AW(AW), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave),
    .ws(ws), .rs1(rs1), .rs2(rs2), .wd(wd),
    .rd1_bus(rd1_bus), .rd2_bus(rd2_bus), .busy(busy)
  );

  always #5 clk = ~clk;

  // Cell bank: write on rising edge while selected, read combinationally OR-ed onto the buses.
  always @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) if (ws[i]) mem[i] <= wd;
  end
  always_comb begin
    rd1_bus = '0;
    rd2_bus = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rs1[i]) rd1_bus = rd1_bus | mem[i];
      if (rs2[i]) rd2_bus = rd2_bus | mem[i];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: pops one expected response per presented response and checks it stays stable.
  always @(negedge clk) begin
    if (!rst_n || !bus.rsp_valid) begin
      seen = 1'b0;
    end else if (!seen) begin
      seen = 1'b1;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_rsp actual=%0h required=none", {bus.rsp_err, bus.rsp_rd1, bus.rsp_rd2});
      end else begin
        last_rsp = exp_q.pop_front();
        chk("rsp_err", 32'(bus.rsp_err), 32'(last_rsp[2*W]));
        chk("rsp_rd1", 32'(bus.rsp_rd1), 32'(last_rsp[2*W-1:W]));
        chk("rsp_rd2", 32'(bus.rsp_rd2), 32'(last_rsp[W-1:0]));
      end
    end else begin
      chk("rsp_stable", 32'({bus.rsp_err, bus.rsp_rd1, bus.rsp_rd2}), 32'(last_rsp));
    end
  end

  task automatic do_write(input logic [AW-1:0] a, input logic [W-1:0] d, input logic [DEPTH-1:0] e_ws);
    @(posedge clk); #1;
    chk("wr_req_ready", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_waddr = a; bus.req_wdata = d;
    @(posedge clk); #1;
    bus.req_valid = 1'b0; bus.req_we = 1'b0;
    @(negedge clk);
    chk("wr_ws", 32'(ws), 32'(e_ws));
    chk("wr_wd", 32'(wd), 32'(d));
    chk("wr_busy", 32'({busy, bus.req_ready, bus.rsp_valid}), 32'b100);
    @(negedge clk);
    chk("wr_ws_clear", 32'(ws), 32'd0);
    chk("wr_back_idle", 32'({busy, bus.req_ready, bus.rsp_valid}), 32'b010);
  endtask

  task automatic do_read(input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                         input logic [DEPTH-1:0] e_rs1, input logic [DEPTH-1:0] e_rs2,
                         input logic [W-1:0] e_rd1, input logic [W-1:0] e_rd2,
                         input logic e_err, input int hold);
    exp_q.push_back({e_err, e_rd1, e_rd2});
    @(posedge clk); #1;
    chk("rd_req_ready", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_raddr1 = a1; bus.req_raddr2 = a2;
    bus.rsp_ready = (hold == 0);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("rd_rs1", 32'(rs1), 32'(e_rs1));
    chk("rd_rs2", 32'(rs2), 32'(e_rs2));
    chk("rd_busy", 32'({ws == '0, busy, bus.req_ready, bus.rsp_valid}), 32'b1100);
    @(negedge clk);
    chk("rd_rs_clear", 32'({rs1, rs2}), 32'd0);
    chk("rd_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_waddr = 3'd0; bus.req_wdata = 15'h5A5A;
      @(negedge clk);
      chk("hold_state", 32'({ws == '0, bus.req_ready, bus.rsp_valid}), 32'b101);
    end
    if (hold > 0) begin
      @(posedge clk); #1;
      bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.rsp_ready = 1'b1;
      @(negedge clk);
      chk("hold_last", 32'(bus.rsp_valid), 32'd1);
    end
    @(negedge clk);
    chk("rsp_done", 32'({bus.rsp_valid, bus.req_ready, busy}), 32'b010);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_waddr = '0; bus.req_wdata = '0;
    bus.req_raddr1 = '0; bus.req_raddr2 = '0; bus.rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_sel", 32'({ws, rs1, rs2}), 32'd0);
    chk("rst_rsp", 32'({bus.rsp_valid, bus.rsp_err, bus.rsp_rd1, bus.rsp_rd2}), 32'd0);
    chk("rst_ctl", 32'({bus.req_ready, busy, wd}), 32'h10000);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_ctl", 32'({bus.req_ready, busy, bus.rsp_valid}), 32'b100);

    do_write(3'd2, 15'h0001, 6'b000100);
    do_read(3'd2, 3'd2, 6'b000100, 6'b000100, 15'h0001, 15'h0001, 1'b0, 0);
    do_write(3'd3, 15'h7FFF, 6'b001000);
    do_write(3'd5, 15'h0002, 6'b100000);
    do_read(3'd3, 3'd5, 6'b001000, 6'b100000, 15'h7FFF, 15'h0002, 1'b0, 0);
    do_read(3'd3, 3'd5, 6'b001000, 6'b100000, 15'h7FFF, 15'h0002, 1'b0, 5);
    do_read(3'd7, 3'd3, 6'b000000, 6'b001000, 15'h0000, 15'h7FFF, 1'b1, 0);
    do_read(3'd6, 3'd6, 6'b000000, 6'b000000, 15'h0000, 15'h0000, 1'b1, 0);
    do_write(3'd7, 15'h2AAA, 6'b000000);
    do_read(3'd2, 3'd5, 6'b000100, 6'b100000, 15'h0001, 15'h0002, 1'b0, 0);
    do_read(3'd0, 3'd1, 6'b000001, 6'b000010, 15'h0000, 15'h0000, 1'b0, 0);

    do_write(3'd4, 15'h1234, 6'b010000);
    @(posedge clk); #1;
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_waddr = 3'd4; bus.req_wdata = 15'h5555;
    @(posedge clk); #1;
    bus.req_valid = 1'b0; bus.req_we = 1'b0;
    chk("rstw_ws_pre", 32'(ws), 32'b010000);
    #2 rst_n = 1'b0;
    #1;
    chk("rstw_ws_async", 32'(ws), 32'd0);
    chk("rstw_ctl", 32'({busy, bus.req_ready, wd}), 32'h08000);
    @(negedge clk);
    rst_n = 1'b1;
    do_read(3'd4, 3'd4, 6'b010000, 6'b010000, 15'h1234, 15'h1234, 1'b0, 0);

    repeat (3) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
